// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// The monitor FSM state encoding and the saturating counter ceiling live here.
package clkdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        TRACK,
        LOCKED,
        STALL
    } mon_state_t;

    // All-ones value of a WIDTH+1 bit counter (CNT_MAX = 2^(WIDTH+1)-1).
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << (width + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/clkdiv_period_meas.sv
// Edge detector and saturating half-period counter for the monitored clock.
// Produces the edge strobe, the length of the half period ending this cycle, and timeout.
module clkdiv_period_meas
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             clk_in,
    output logic             edge_seen,
    output logic [WIDTH:0]   measured,
    output logic             timeout
);

    localparam int unsigned    CW      = WIDTH + 1;
    localparam logic [WIDTH:0] CNT_MAX = CW'(cnt_max(WIDTH));
    localparam logic [WIDTH:0] TO_LAST = CW'(TIMEOUT - 1);

    logic           clk_in_d;
    logic [WIDTH:0] cnt;
    logic [WIDTH:0] cnt_inc;

    assign edge_seen = clk_in ^ clk_in_d;
    assign cnt_inc   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    // The edge cycle itself is part of the half period, hence cnt+1.
    assign measured  = cnt_inc;
    assign timeout   = (cnt == TO_LAST) && !edge_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_in_d <= 1'b0;
            cnt      <= '0;
        end else begin
            clk_in_d <= clk_in;
            if (clear || edge_seen) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/clkdiv_monitor.sv
// Receive-side checker for the even-ratio divided clock: measures each half period
// and reports lock, wrong-length pulses and stall to the AGC control logic.
module clkdiv_monitor
    import clkdiv_pkg::*;
#(
    parameter int unsigned N        = 2,
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           clk_in,
    output logic           locked,
    output logic           err,
    output logic           stall,
    output logic [WIDTH:0] half_period
);

    localparam int unsigned    CW     = WIDTH + 1;
    localparam logic [WIDTH:0] N_V    = CW'(N);
    localparam logic [WIDTH:0] LOCK_V = CW'(LOCK_CNT);

    mon_state_t     state, state_n;
    logic [WIDTH:0] good_cnt, good_cnt_n;
    logic [WIDTH:0] good_inc;
    logic           locked_n, err_n, stall_n;
    logic [WIDTH:0] half_period_n;

    logic           edge_seen;
    logic           timeout;
    logic [WIDTH:0] measured;
    logic           cnt_clear;

    assign cnt_clear = (state == IDLE) || !start;
    assign good_inc  = good_cnt + 1'b1;

    clkdiv_period_meas #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_meas (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .clk_in    (clk_in),
        .edge_seen (edge_seen),
        .measured  (measured),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            good_cnt    <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            stall       <= 1'b0;
            half_period <= '0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_cnt_n;
            locked      <= locked_n;
            err         <= err_n;
            stall       <= stall_n;
            half_period <= half_period_n;
        end
    end

    always_comb begin
        state_n       = state;
        good_cnt_n    = good_cnt;
        locked_n      = locked;
        err_n         = 1'b0;
        stall_n       = stall;
        half_period_n = half_period;

        if (!start) begin
            // Disable wins over everything but reset; half_period deliberately holds.
            state_n    = IDLE;
            good_cnt_n = '0;
            locked_n   = 1'b0;
            stall_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    locked_n   = 1'b0;
                    stall_n    = 1'b0;
                    good_cnt_n = '0;
                    state_n    = ACQ;
                end
                ACQ: begin
                    if (edge_seen) begin
                        state_n    = TRACK;
                        good_cnt_n = '0;
                    end else if (timeout) begin
                        state_n  = STALL;
                        stall_n  = 1'b1;
                        locked_n = 1'b0;
                    end
                end
                TRACK: begin
                    if (edge_seen) begin
                        half_period_n = measured;
                        if (measured == N_V) begin
                            good_cnt_n = good_inc;
                            if (good_inc == LOCK_V) begin
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                            end
                        end else begin
                            err_n      = 1'b1;
                            good_cnt_n = '0;
                        end
                    end else if (timeout) begin
                        state_n  = STALL;
                        stall_n  = 1'b1;
                        locked_n = 1'b0;
                    end
                end
                LOCKED: begin
                    if (edge_seen) begin
                        half_period_n = measured;
                        if (measured != N_V) begin
                            err_n      = 1'b1;
                            locked_n   = 1'b0;
                            good_cnt_n = '0;
                            state_n    = TRACK;
                        end
                    end else if (timeout) begin
                        locked_n = 1'b0;
                        stall_n  = 1'b1;
                        state_n  = STALL;
                    end
                end
                STALL: begin
                    stall_n  = 1'b1;
                    locked_n = 1'b0;
                    if (edge_seen) begin
                        state_n       = TRACK;
                        stall_n       = 1'b0;
                        good_cnt_n    = '0;
                        half_period_n = measured;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Randomised and directed check of clkdiv_monitor against a cycle-count reference model.
// A second instance with a narrow counter exercises saturation of the measured half period.
module tb_clkdiv_monitor;

    localparam int N_P    = 2;
    localparam int LOCK_P = 4;
    localparam int TO_P   = 64;
    localparam int MAXV   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clk_in = 1'b0;
    logic       clk_in2 = 1'b0;
    logic       locked, err, stall;
    logic [7:0] half_period;
    logic       locked_s, err_s, stall_s;
    logic [3:0] half_period_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clkdiv_monitor #(
        .N        (N_P),
        .WIDTH    (7),
        .LOCK_CNT (LOCK_P),
        .TIMEOUT  (TO_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clk_in      (clk_in),
        .locked      (locked),
        .err         (err),
        .stall       (stall),
        .half_period (half_period)
    );

    clkdiv_monitor #(
        .N        (2),
        .WIDTH    (3),
        .LOCK_CNT (4),
        .TIMEOUT  (15)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clk_in      (clk_in2),
        .locked      (locked_s),
        .err         (err_s),
        .stall       (stall_s),
        .half_period (half_period_s)
    );

    // Reference model: tracks absolute cycle numbers rather than a counter register.
    int m_cyc = 0;
    int m_last_ref = 0;
    bit m_prev = 0, m_active = 0, m_have_ref = 0, m_locked = 0, m_stalled = 0, m_err = 0;
    int m_run = 0;
    int m_hp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_active = 0; m_have_ref = 0; m_locked = 0;
        m_stalled = 0; m_err = 0; m_run = 0; m_hp = 0;
        m_last_ref = m_cyc;
    endtask

    task automatic model_step();
        int el, meas;
        bit e;
        e = (clk_in != m_prev);
        m_err = 0;
        if (!start) begin
            m_active = 0; m_locked = 0; m_stalled = 0; m_run = 0;
            m_last_ref = m_cyc + 1;
        end else if (!m_active) begin
            m_active = 1; m_have_ref = 0; m_run = 0;
            m_last_ref = m_cyc + 1;
        end else begin
            el = m_cyc - m_last_ref;
            if (e) begin
                meas = (el + 1 > MAXV) ? MAXV : el + 1;
                m_last_ref = m_cyc + 1;
                if (!m_have_ref) begin
                    m_have_ref = 1; m_run = 0;
                end else begin
                    m_hp = meas;
                    if (m_stalled) begin
                        m_stalled = 0; m_run = 0;
                    end else if (meas == N_P) begin
                        if (!m_locked) begin
                            m_run++;
                            if (m_run == LOCK_P) m_locked = 1;
                        end
                    end else begin
                        m_err = 1; m_run = 0; m_locked = 0;
                    end
                end
            end else if (el == TO_P - 1 && !m_stalled) begin
                m_stalled = 1; m_have_ref = 1; m_locked = 0;
            end
        end
        m_prev = clk_in;
        m_cyc++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("locked", 32'(locked), 32'(m_locked));
        chk("err", 32'(err), 32'(m_err));
        chk("stall", 32'(stall), 32'(m_stalled));
        chk("half_period", 32'(half_period), 32'(m_hp));
    endtask

    task automatic half(input int len);
        clk_in = ~clk_in;
        repeat (len) cycle();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        clk_in = 1'b0;
        clk_in2 = 1'b0;
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_half_period", 32'(half_period), 0);
        chk("rst_s_stall", 32'(stall_s), 0);
        chk("rst_s_half_period", 32'(half_period_s), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int r;
        @(posedge clk);
        #1;
        do_reset();

        // Nominal lock: first edge only acquires, four good halves lock.
        start = 1'b1;
        cycle();
        repeat (5) half(N_P);
        chk("lock_nominal", 32'(locked), 1);
        chk("lock_nominal_hp", 32'(half_period), 2);
        repeat (3) half(N_P);

        // Wrong ratio.
        repeat (6) half(3);
        chk("wrong_ratio_locked", 32'(locked), 0);
        chk("wrong_ratio_hp", 32'(half_period), 3);

        // Lock loss and relock.
        repeat (6) half(N_P);
        chk("relock", 32'(locked), 1);
        half(5);
        half(N_P);
        chk("loss_locked", 32'(locked), 0);
        chk("loss_hp", 32'(half_period), 5);
        repeat (4) half(N_P);
        chk("relock_after_loss", 32'(locked), 1);

        // Stall and recovery.
        repeat (70) cycle();
        chk("stall_level", 32'(stall), 1);
        chk("stall_locked", 32'(locked), 0);
        repeat (5) half(N_P);
        chk("stall_recover", 32'(stall), 0);
        chk("stall_relock", 32'(locked), 1);

        // Drop start for one cycle.
        start = 1'b0;
        cycle();
        chk("start_drop_locked", 32'(locked), 0);
        chk("start_drop_hp_held", 32'(half_period), 2);
        start = 1'b1;
        cycle();
        repeat (5) half(N_P);
        chk("start_relock", 32'(locked), 1);

        // Random mix of good, wrong, stalling halves and start drops.
        repeat (300) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) half(N_P);
            else if (r < 90) half(int'($urandom_range(1, 6)));
            else if (r < 95) half(int'($urandom_range(60, 75)));
            else begin
                start = 1'b0;
                cycle();
                start = 1'b1;
            end
        end

        // Asynchronous reset mid-operation.
        repeat (6) half(N_P);
        do_reset();

        // Saturation on the narrow instance: 20-cycle halves against a 4-bit counter.
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            clk_in2 = ~clk_in2;
            repeat (20) begin
                cycle();
                chk("sat_hp_bound", 32'(half_period_s <= 4'd15), 1);
                chk("sat_err", 32'(err_s), 0);
            end
            if (k >= 1) begin
                chk("sat_stall", 32'(stall_s), 1);
                chk("sat_hp", 32'(half_period_s), 15);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
